lstm_h_history: RTL and testbench

Parametrised hidden-state history buffer for the LSTM datapath. It accepts the h-vector of each timestep as a stream of NUM_LSTM elements and commits one timestep per NUM_LSTM accepted writes. It returns any committed timestep as one wide, registered vector to the gate and backprop stages. Step 0 is the implicit all-zero initial state.

---
 rtl/lstm_h_history.sv | 112 +++++++++++
 tb/tb_lstm_h_history.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lstm_h_history.sv
// Hidden-state history buffer: streams h elements in, commits one timestep
// per NUM_LSTM writes, and returns any committed step as a registered vector.
module lstm_h_history #(
   parameter  int WIDTH    = 32,
   parameter  int NUM_LSTM = 53,
   parameter  int TIMESTEP = 7,
   localparam int STEP_W   = $clog2(TIMESTEP + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      seq_start,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [WIDTH-1:0]          wr_data,
   output logic [STEP_W-1:0]         wr_step,
   output logic                      full,
   input  logic                      rd_req,
   input  logic [STEP_W-1:0]         rd_step,
   output logic                      rd_valid,
   output logic [NUM_LSTM*WIDTH-1:0] rd_data,
   output logic                      rd_err
);

   localparam int CNT_W = (NUM_LSTM > 1) ? $clog2(NUM_LSTM) : 1;
   localparam int VEC_W = NUM_LSTM * WIDTH;

   logic [CNT_W-1:0]  elem_cnt_q, elem_cnt_d;
   logic [STEP_W-1:0] wr_step_q, wr_step_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_err_q, rd_err_d;
   logic [VEC_W-1:0]  rd_data_q, rd_data_d;
   logic [VEC_W-1:0]  rd_vec;
   logic [VEC_W-1:0]  mem_q [TIMESTEP];
   logic              full_w;
   logic              wr_fire;

   assign full_w   = (wr_step_q == STEP_W'(TIMESTEP));
   assign wr_ready = !rst && !full_w && !seq_start;
   assign wr_fire  = wr_valid && wr_ready;

   assign wr_step  = wr_step_q;
   assign full     = full_w;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_err   = rd_err_q;

   always_comb begin
      elem_cnt_d = elem_cnt_q;
      wr_step_d  = wr_step_q;
      if (seq_start) begin
         elem_cnt_d = '0;
         wr_step_d  = '0;
      end else if (wr_fire) begin
         if (elem_cnt_q == CNT_W'(NUM_LSTM - 1)) begin
            elem_cnt_d = '0;
            wr_step_d  = wr_step_q + STEP_W'(1);
         end else begin
            elem_cnt_d = elem_cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      rd_vec = '0;
      for (int s = 0; s < TIMESTEP; s++) begin
         if (rd_step == STEP_W'(s + 1)) rd_vec = mem_q[s];
      end
   end

   // Legality uses the pre-edge wr_step, so a same-cycle commit is not seen.
   always_comb begin
      rd_valid_d = rd_req;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q;
      if (rd_req) begin
         rd_data_d = '0;
         rd_err_d  = 1'b0;
         if (rd_step != '0) begin
            if (rd_step <= wr_step_q) rd_data_d = rd_vec;
            else rd_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         elem_cnt_q <= '0;
         wr_step_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         elem_cnt_q <= elem_cnt_d;
         wr_step_q  <= wr_step_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Storage is deliberately not reset; stale steps are gated by wr_step.
   always_ff @(posedge clk) begin
      for (int s = 0; s < TIMESTEP; s++) begin
         for (int k = 0; k < NUM_LSTM; k++) begin
            if (wr_fire && wr_step_q == STEP_W'(s)
                && elem_cnt_q == CNT_W'(k))
               mem_q[s][k*WIDTH +: WIDTH] <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_lstm_h_history.sv
// Self-checking bench for lstm_h_history: behavioural model compared every
// cycle, plus literal expectations from hand-computed directed vectors.
module tb_lstm_h_history;

   localparam int W  = 32;
   localparam int NL = 4;
   localparam int TS = 3;
   localparam int SW = $clog2(TS + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              seq_start = 1'b0;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [W-1:0]      wr_data = '0;
   logic [SW-1:0]     wr_step;
   logic              full;
   logic              rd_req = 1'b0;
   logic [SW-1:0]     rd_step = '0;
   logic              rd_valid;
   logic [NL*W-1:0]   rd_data;
   logic              rd_err;

   int n_checks = 0;
   int n_fail   = 0;

   lstm_h_history #(.WIDTH(W), .NUM_LSTM(NL), .TIMESTEP(TS)) dut (
      .clk(clk), .rst(rst), .seq_start(seq_start),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .wr_step(wr_step), .full(full),
      .rd_req(rd_req), .rd_step(rd_step), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [NL*W-1:0] act,
                      input logic [NL*W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Model: list of committed vectors plus a partial vector being filled.
   logic [W-1:0]    m_vec [1:TS][NL];
   logic [W-1:0]    m_part [NL];
   int              m_step = 0;
   int              m_cnt = 0;
   logic            e_rv = 1'b0;
   logic            e_err = 1'b0;
   logic [NL*W-1:0] e_data = '0;

   function automatic logic [NL*W-1:0] pack(input int s);
      logic [NL*W-1:0] v = '0;
      for (int k = 0; k < NL; k++) v[k*W +: W] = m_vec[s][k];
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_step = 0;
         m_cnt  = 0;
         e_rv   = 1'b0;
         e_err  = 1'b0;
         e_data = '0;
      end else begin
         e_rv = rd_req;
         if (rd_req) begin
            if (rd_step == 0) begin
               e_data = '0;
               e_err  = 1'b0;
            end else if (int'(rd_step) <= m_step) begin
               e_data = pack(int'(rd_step));
               e_err  = 1'b0;
            end else begin
               e_data = '0;
               e_err  = 1'b1;
            end
         end
         if (seq_start) begin
            m_step = 0;
            m_cnt  = 0;
         end else if (wr_valid && m_step < TS) begin
            m_part[m_cnt] = wr_data;
            m_cnt++;
            if (m_cnt == NL) begin
               m_step++;
               for (int k = 0; k < NL; k++) m_vec[m_step][k] = m_part[k];
               m_cnt = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("m_wr_step", NL*W'(wr_step), NL*W'(m_step));
      chk("m_full", NL*W'(full), NL*W'(m_step == TS));
      chk("m_wr_ready", NL*W'(wr_ready),
          NL*W'(!rst && m_step != TS && !seq_start));
      chk("m_rd_valid", NL*W'(rd_valid), NL*W'(e_rv));
      chk("m_rd_err", NL*W'(rd_err), NL*W'(e_err));
      chk("m_rd_data", rd_data, e_data);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [W-1:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      cyc();
      wr_valid = 1'b0;
   endtask

   task automatic rd(input int s);
      rd_req  = 1'b1;
      rd_step = SW'(s);
      cyc();
      rd_req  = 1'b0;
   endtask

   initial begin
      repeat (3) cyc();
      chk("rst_wr_ready", NL*W'(wr_ready), '0);
      chk("rst_rd_data", rd_data, '0);
      rst = 1'b0;
      cyc();
      chk("ready_after_rst", NL*W'(wr_ready), NL*W'(1));

      rd(0);
      chk("rd0_valid", NL*W'(rd_valid), NL*W'(1));
      chk("rd0_err", NL*W'(rd_err), '0);
      chk("rd0_data", rd_data, '0);
      rd(1);
      chk("rd1_err", NL*W'(rd_err), NL*W'(1));
      chk("rd1_data", rd_data, '0);
      cyc();
      chk("rd_pulse_end", NL*W'(rd_valid), '0);
      chk("rd_err_hold", NL*W'(rd_err), NL*W'(1));

      wr_valid = 1'b1;
      wr_data = 32'h11; cyc();
      wr_data = 32'h22; cyc();
      wr_data = 32'h33; cyc();
      chk("step_before_4th", NL*W'(wr_step), '0);
      wr_data = 32'h44; cyc();
      wr_valid = 1'b0;
      chk("step1_commit", NL*W'(wr_step), NL*W'(1));
      rd(1);
      chk("step1_data", rd_data, 128'h00000044_00000033_00000022_00000011);
      chk("step1_err", NL*W'(rd_err), '0);

      wr(32'h21); wr(32'h22); wr(32'h23);
      wr_valid = 1'b1;
      wr_data  = 32'h24;
      rd_req   = 1'b1;
      rd_step  = SW'(2);
      cyc();
      wr_valid = 1'b0;
      chk("same_cycle_err", NL*W'(rd_err), NL*W'(1));
      chk("same_cycle_step", NL*W'(wr_step), NL*W'(2));
      cyc();
      rd_req = 1'b0;
      chk("next_cycle_err", NL*W'(rd_err), '0);
      chk("next_cycle_data", rd_data,
          128'h00000024_00000023_00000022_00000021);

      wr(32'h31); wr(32'h32); wr(32'h33); wr(32'h34);
      chk("full_set", NL*W'(full), NL*W'(1));
      chk("full_ready", NL*W'(wr_ready), '0);
      wr(32'hFF); wr(32'hEE);
      chk("full_step_hold", NL*W'(wr_step), NL*W'(3));
      rd(3);
      chk("step3_data", rd_data, 128'h00000034_00000033_00000032_00000031);

      seq_start = 1'b1;
      cyc();
      seq_start = 1'b0;
      chk("seq_clear_full", NL*W'(full), '0);
      wr(32'h55); wr(32'h66);
      seq_start = 1'b1;
      wr(32'h77);
      seq_start = 1'b0;
      wr(32'hA); wr(32'hB); wr(32'hC); wr(32'hD);
      chk("seq_step", NL*W'(wr_step), NL*W'(1));
      rd(1);
      chk("seq_data", rd_data, 128'h0000000D_0000000C_0000000B_0000000A);
      rd(2);
      chk("stale_step2_err", NL*W'(rd_err), NL*W'(1));
      chk("stale_step2_data", rd_data, '0);

      wr(32'h1); wr(32'h2);
      rd_req  = 1'b1;
      rd_step = SW'(1);
      #2 rst = 1'b1;
      cyc();
      rd_req = 1'b0;
      chk("rst_mid_valid", NL*W'(rd_valid), '0);
      chk("rst_mid_step", NL*W'(wr_step), '0);
      chk("rst_mid_err", NL*W'(rd_err), '0);
      chk("rst_mid_ready", NL*W'(wr_ready), '0);
      rst = 1'b0;
      cyc();
      rd(1);
      chk("after_rst_err", NL*W'(rd_err), NL*W'(1));
      chk("after_rst_data", rd_data, '0);
      repeat (2) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
